// File: rtl/video_timing_ctrl_if.sv
// Pixel fetch bus between the timing controller (master) and the pixel source (slave).
// The master requests (fetch_x, fetch_y); the source answers on r_in/g_in/b_in a fixed lead later.
interface video_timing_ctrl_if;
    logic        fetch;
    logic [11:0] fetch_x;
    logic [10:0] fetch_y;
    logic [7:0]  r_in;
    logic [7:0]  g_in;
    logic [7:0]  b_in;

    modport master (
        output fetch,
        output fetch_x,
        output fetch_y,
        input  r_in,
        input  g_in,
        input  b_in
    );

    modport slave (
        input  fetch,
        input  fetch_x,
        input  fetch_y,
        output r_in,
        output g_in,
        output b_in
    );
endinterface

// File: rtl/video_timing_ctrl.sv
// Video timing controller: raster counters, early pixel fetch, and re-aligned de/sync/rgb outputs.
// Build option VTC_TESTPAT_EN adds a per-frame selectable 8-bar colour test pattern.
module video_timing_ctrl #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b0,
    parameter int unsigned FETCH_LEAD = 2
) (
    input  logic                       clk_pix,
    input  logic                       reset,
    input  logic                       enable,
`ifdef VTC_TESTPAT_EN
    input  logic                       testpat,
`endif
    video_timing_ctrl_if.master        pix,
    output logic [7:0]                 r,
    output logic [7:0]                 g,
    output logic [7:0]                 b,
    output logic                       de,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       frame_start,
    output logic                       line_start,
    output logic                       busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    // Per-position flags in asserted sense; polarity is applied only at the output register.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       ls;
        logic       tp;
        logic [2:0] bar;
    } flags_t;

    state_t      state_q;
    logic [11:0] h_q;
    logic [10:0] v_q;
    flags_t      pipe_q [FETCH_LEAD+1];

    logic        at_origin;
    logic        run;
    logic        h_wrap;
    logic        v_wrap;
    logic        tp_cur;
    logic [2:0]  bar;
    flags_t      cur;
    flags_t      out_f;

`ifdef VTC_TESTPAT_EN
    logic testpat_q;
    // The frame's first position must already see the newly sampled request.
    assign tp_cur = at_origin ? testpat : testpat_q;
`else
    assign tp_cur = 1'b0;
`endif

    assign out_f = pipe_q[FETCH_LEAD];

    always_comb begin
        bar = 3'd0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (h_q >= 12'(i * BAR_W)) bar = 3'(i);
        end
    end

    // h_q/v_q hold the position fetched on the next running edge; (0,0) is the frame boundary
    // where enable decides between starting/continuing and dropping to idle.
    always_comb begin
        at_origin = (h_q == 12'd0) && (v_q == 11'd0);
        run       = enable || ((state_q == StRun) && !at_origin);
        h_wrap    = (h_q == H_LAST);
        v_wrap    = (v_q == V_LAST);
        cur       = '0;
        if (run) begin
            cur.de  = (h_q < H_ACT) && (v_q < V_ACT);
            cur.hs  = (h_q >= HS_BEG) && (h_q < HS_END);
            cur.vs  = (v_q >= VS_BEG) && (v_q < VS_END);
            cur.fs  = cur.de && at_origin;
            cur.ls  = cur.de && (h_q == 12'd0);
            cur.tp  = tp_cur;
            cur.bar = bar;
        end
    end

    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            h_q         <= 12'd0;
            v_q         <= 11'd0;
`ifdef VTC_TESTPAT_EN
            testpat_q   <= 1'b0;
`endif
            pix.fetch   <= 1'b0;
            pix.fetch_x <= 12'd0;
            pix.fetch_y <= 11'd0;
            for (int unsigned i = 0; i <= FETCH_LEAD; i++) pipe_q[i] <= '0;
            de          <= 1'b0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            r           <= 8'd0;
            g           <= 8'd0;
            b           <= 8'd0;
        end else begin
            state_q <= run ? StRun : StIdle;
            busy    <= run;

            if (run) begin
                h_q <= h_wrap ? 12'd0 : h_q + 12'd1;
                if (h_wrap) v_q <= v_wrap ? 11'd0 : v_q + 11'd1;
            end
`ifdef VTC_TESTPAT_EN
            if (run && at_origin) testpat_q <= testpat;
`endif

            pix.fetch   <= cur.de && !cur.tp;
            pix.fetch_x <= (cur.de && !cur.tp) ? h_q : 12'd0;
            pix.fetch_y <= (cur.de && !cur.tp) ? v_q : 11'd0;

            pipe_q[0] <= cur;
            for (int unsigned i = 1; i <= FETCH_LEAD; i++) pipe_q[i] <= pipe_q[i-1];

            de          <= out_f.de;
            hsync       <= out_f.hs ? H_POL : ~H_POL;
            vsync       <= out_f.vs ? V_POL : ~V_POL;
            frame_start <= out_f.fs;
            line_start  <= out_f.ls;

            // Bar colour bits: red on bars 0,1,4,5; green on 0..3; blue on even bars.
            if (!out_f.de) begin
                r <= 8'd0;
                g <= 8'd0;
                b <= 8'd0;
            end else if (out_f.tp) begin
                r <= {8{~out_f.bar[1]}};
                g <= {8{~out_f.bar[2]}};
                b <= {8{~out_f.bar[0]}};
            end else begin
                r <= pix.r_in;
                g <= pix.g_in;
                b <= pix.b_in;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on a 14x7 raster: frame-index model checked every cycle,
// plus hand-computed expectations at start-up, sync edges, enable drop and mid-line reset.
`timescale 1ns/1ps
module tb_video_timing_ctrl;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk_pix = 1'b0;
    logic       reset;
    logic       enable;
`ifdef VTC_TESTPAT_EN
    logic       testpat;
`endif
    logic [7:0] r, g, b;
    logic       de, hsync, vsync, frame_start, line_start, busy;

    video_timing_ctrl_if pix ();

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .FETCH_LEAD(2)
    ) dut (
        .clk_pix(clk_pix),
        .reset(reset),
        .enable(enable),
`ifdef VTC_TESTPAT_EN
        .testpat(testpat),
`endif
        .pix(pix),
        .r(r),
        .g(g),
        .b(b),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .frame_start(frame_start),
        .line_start(line_start),
        .busy(busy)
    );

    always #5 clk_pix = ~clk_pix;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pixel source: answers each request two edges later; junk when no request was made.
    typedef struct packed {logic v; logic [11:0] x; logic [10:0] y;} req_t;
    req_t src_q [3];
    always begin
        @(posedge clk_pix);
        #1;
        src_q[2] = src_q[1];
        src_q[1] = src_q[0];
        src_q[0] = {pix.fetch, pix.fetch_x, pix.fetch_y};
        if (src_q[2].v === 1'b1) begin
            pix.r_in = src_q[2].x[7:0];
            pix.g_in = src_q[2].y[7:0];
            pix.b_in = src_q[2].x[7:0] ^ src_q[2].y[7:0];
        end else begin
            pix.r_in = 8'hA5;
            pix.g_in = 8'h5A;
            pix.b_in = 8'hC3;
        end
    end

    // Model: positions are a flat index 0..FT-1 into the frame; outputs derive from the
    // position fetched three edges earlier using the raster rules directly.
    typedef struct {bit v; int p; bit tp;} mpos_t;
    mpos_t hist [4];
    bit    m_run, m_go, m_tp;
    int    m_cyc, h0, v0, h3, v3;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    logic [31:0] e_fetch, e_x, e_y, e_de, e_hs, e_vs, e_fs, e_ls, e_rgb, e_busy;

    always begin
        @(posedge clk_pix or posedge reset);
        if (reset) begin
            m_run = 1'b0;
            m_cyc = 0;
            m_tp  = 1'b0;
            for (int i = 0; i < 4; i++) hist[i] = '{1'b0, 0, 1'b0};
        end else begin
            m_go = enable || (m_run && m_cyc != 0);
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
`ifdef VTC_TESTPAT_EN
            if (m_go && m_cyc == 0) m_tp = testpat;
`endif
            hist[0] = '{m_go, m_cyc, m_tp};
            if (m_go) m_cyc = (m_cyc + 1) % FT;
            m_run = m_go;
        end
        h0 = hist[0].p % HT;  v0 = hist[0].p / HT;
        h3 = hist[3].p % HT;  v3 = hist[3].p / HT;
        e_fetch = 32'(hist[0].v && h0 < HA && v0 < VA && !hist[0].tp);
        e_x     = e_fetch[0] ? 32'(h0) : 32'd0;
        e_y     = e_fetch[0] ? 32'(v0) : 32'd0;
        e_de    = 32'(hist[3].v && h3 < HA && v3 < VA);
        e_hs    = 32'(!(hist[3].v && h3 >= HA + HF && h3 < HA + HF + HS));
        e_vs    = 32'(!(hist[3].v && v3 >= VA + VF && v3 < VA + VF + VS));
        e_fs    = 32'(e_de[0] && hist[3].p == 0);
        e_ls    = 32'(e_de[0] && h3 == 0);
        if (!e_de[0])         e_rgb = 32'd0;
        else if (hist[3].tp)  e_rgb = 32'(bars[h3 / (HA / 8)]);
        else                  e_rgb = 32'({8'(h3), 8'(v3), 8'(h3 ^ v3)});
        e_busy  = 32'(m_run);
    end

    always begin
        @(negedge clk_pix);
        if (cmp_en) begin
            chk("fetch",       32'(pix.fetch),   e_fetch);
            chk("fetch_x",     32'(pix.fetch_x), e_x);
            chk("fetch_y",     32'(pix.fetch_y), e_y);
            chk("de",          32'(de),          e_de);
            chk("hsync",       32'(hsync),       e_hs);
            chk("vsync",       32'(vsync),       e_vs);
            chk("frame_start", 32'(frame_start), e_fs);
            chk("line_start",  32'(line_start),  e_ls);
            chk("rgb",         32'({r, g, b}),   e_rgb);
            chk("busy",        32'(busy),        e_busy);
        end
    end

    // Starts (or restarts) the raster and pins hand-computed values; j counts edges from start.
    task automatic run_frames(input int ncyc, input int drop_at, input bit pat);
        int fend;
        fend = (drop_at >= 0) ? (drop_at / FT + 1) * FT : -1;
        @(negedge clk_pix);
        reset  = 1'b0;
        enable = 1'b1;
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clk_pix);
            case (j)
                0: begin
                    chk("lit_busy_rise", 32'(busy), 32'd1);
                    chk("lit_fetch0",    32'(pix.fetch), 32'(!pat));
                    chk("lit_fetch_x0",  32'(pix.fetch_x), 32'd0);
                end
                2:  chk("lit_de_pre",    32'(de), 32'd0);
                3: begin
                    chk("lit_de_first",  32'(de), 32'd1);
                    chk("lit_fs_first",  32'(frame_start), 32'd1);
                    chk("lit_ls_first",  32'(line_start), 32'd1);
                    chk("lit_rgb_x0",    32'({r, g, b}), pat ? 32'h00FFFFFF : 32'h0);
                end
                4: begin
                    chk("lit_fs_once",   32'(frame_start), 32'd0);
                    chk("lit_rgb_x1",    32'({r, g, b}), pat ? 32'h00FFFF00 : 32'h00010001);
                end
                7:  chk("lit_fetch_x7",  32'(pix.fetch_x), pat ? 32'd0 : 32'd7);
                8:  chk("lit_fetch_end", 32'(pix.fetch), 32'd0);
                10: begin
                    chk("lit_de_last",   32'(de), 32'd1);
                    chk("lit_rgb_x7",    32'({r, g, b}), pat ? 32'h0 : 32'h00070007);
                end
                11: begin
                    chk("lit_de_fall",   32'(de), 32'd0);
                    chk("lit_rgb_blank", 32'({r, g, b}), 32'd0);
                end
                12: chk("lit_hs_pre",    32'(hsync), 32'd1);
                13: chk("lit_hs_on",     32'(hsync), 32'd0);
                14: chk("lit_hs_on2",    32'(hsync), 32'd0);
                15: chk("lit_hs_off",    32'(hsync), 32'd1);
                17: begin
                    chk("lit_ls_line1",  32'(line_start), 32'd1);
                    chk("lit_rgb_y1",    32'({r, g, b}), pat ? 32'h00FFFFFF : 32'h00000101);
                end
                72: chk("lit_vs_pre",    32'(vsync), 32'd1);
                73: chk("lit_vs_on",     32'(vsync), 32'd0);
                86: chk("lit_vs_on_end", 32'(vsync), 32'd0);
                87: chk("lit_vs_off",    32'(vsync), 32'd1);
                default: ;
            endcase
            if (j == fend - 1) chk("lit_busy_last_edge", 32'(busy), 32'd1);
            if (j == fend) begin
                chk("lit_busy_fall",  32'(busy), 32'd0);
                chk("lit_fetch_idle", 32'(pix.fetch), 32'd0);
            end
            if (j == drop_at) enable = 1'b0;
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
`ifdef VTC_TESTPAT_EN
        testpat = 1'b0;
`endif
        repeat (3) @(negedge clk_pix);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_fetch", 32'(pix.fetch), 32'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        repeat (5) @(negedge clk_pix);

        // Two full frames, enable dropped during line 2 of the third, then idle.
        run_frames(3 * FT + 26, 2 * FT + 30, 1'b0);
        repeat (10) @(negedge clk_pix);

        // Re-enable, then reset while an active pixel is on the output.
        run_frames(21, -1, 1'b0);
        chk("pre_rst_de", 32'(de), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_de",    32'(de), 32'd0);
        chk("mid_rst_rgb",   32'({r, g, b}), 32'd0);
        chk("mid_rst_hsync", 32'(hsync), 32'd1);
        chk("mid_rst_vsync", 32'(vsync), 32'd1);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_fetch", 32'(pix.fetch), 32'd0);
        run_frames(FT + 2, -1, 1'b0);

`ifdef VTC_TESTPAT_EN
        #2 reset = 1'b1;
        testpat = 1'b1;
        run_frames(40, -1, 1'b1);
        testpat = 1'b0;
        repeat (FT) @(negedge clk_pix);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
